// File: rtl/pe_lin_pkg.sv
// Shared types for the linear-chain feeder: FSM states and default geometry.
package pe_lin_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;

  typedef logic [DW_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/pe_lin_feeder_skew_line.sv
// Zero-fill delay line of DEPTH registers; lane i of the feeder uses DEPTH=i+1.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_sr [0:DEPTH-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/pe_lin_feeder.sv
// Feeder for a linear PE chain: registers head fire/activation, skews weights per PE.
// Optional perf counters (perf_beats/perf_bubbles) when PE_LIN_FEEDER_PERF_EN is defined.
//   state    | meaning
//   S_IDLE   | no vector in progress, ready for first beat
//   S_STREAM | vector open, accepting beats (gaps are bubbles)
//   S_DRAIN  | last beat accepted, waiting for it to pass PE N-1
//   S_DONE   | one-cycle done pulse
module pe_lin_feeder
  import pe_lin_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_a,
  input  logic [DW-1:0] s_w [0:N-1],
  input  logic          s_last,
  output logic          pe_fire,
  output logic [DW-1:0] pe_a,
  output logic [DW-1:0] pe_w [0:N-1],
  output logic          busy,
  output logic          done
`ifdef PE_LIN_FEEDER_PERF_EN
  ,
  output logic [CW-1:0] perf_beats,
  output logic [CW-1:0] perf_bubbles
`endif
);

  localparam int DCW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_next;
  logic [DCW-1:0] r_dcnt;
  logic           r_fire;
  logic [DW-1:0]  r_a;
  logic           w_accept;
  logic [DW-1:0]  w_lane_in [0:N-1];

  assign w_accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_STREAM: if (w_accept) w_next = s_last ? S_DRAIN : S_STREAM;
      S_DRAIN:          if (r_dcnt == DCW'(1)) w_next = S_DONE;
      S_DONE:           w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_IDLE:   s_ready = 1'b1;
      S_STREAM: begin s_ready = 1'b1; busy = 1'b1; end
      S_DRAIN:  busy = 1'b1;
      S_DONE:   done = 1'b1;
      default:  s_ready = 1'b0;
    endcase
  end

  // Drain timer: loaded with N on the last accept, DONE follows its terminal count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      r_dcnt <= '0;
    else if (w_accept && s_last)    r_dcnt <= DCW'(N);
    else if (r_state == S_DRAIN)    r_dcnt <= r_dcnt - DCW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fire <= 1'b0;
      r_a    <= '0;
    end else begin
      r_fire <= w_accept;
      r_a    <= w_accept ? s_a : '0;
    end
  end

  assign pe_fire = r_fire;
  assign pe_a    = r_a;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign w_lane_in[gi] = w_accept ? s_w[gi] : '0;
    skew_line #(.DEPTH(gi + 1), .DW(DW)) u_skew (
      .clk  (clk),
      .rstn (rstn),
      .i_d  (w_lane_in[gi]),
      .o_q  (pe_w[gi])
    );
  end

`ifdef PE_LIN_FEEDER_PERF_EN
  localparam logic [CW-1:0] SAT = '1;
  logic [CW-1:0] r_beats;
  logic [CW-1:0] r_bubbles;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beats   <= '0;
      r_bubbles <= '0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_beats   <= CW'(1);
      r_bubbles <= '0;
    end else if (r_state == S_STREAM) begin
      if (w_accept && r_beats != SAT)    r_beats   <= r_beats + CW'(1);
      if (!s_valid && r_bubbles != SAT)  r_bubbles <= r_bubbles + CW'(1);
    end
  end

  assign perf_beats   = r_beats;
  assign perf_bubbles = r_bubbles;
`endif

endmodule

// File: tb/tb_pe_lin_feeder.sv
// Bench for pe_lin_feeder: directed + random beats against an edge-indexed history model.
module tb_pe_lin_feeder;
  import pe_lin_pkg::*;

  localparam int N    = N_DEF;
  localparam int DW   = DW_DEF;
  localparam int MAXE = 1024;
`ifdef PE_LIN_FEEDER_PERF_EN
  localparam int TB_CW = 4;
`else
  localparam int TB_CW = 16;
`endif
  localparam int SATV = (1 << TB_CW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_a;
  logic [DW-1:0] s_w [0:N-1];
  logic          pe_fire, busy, done;
  logic [DW-1:0] pe_a;
  logic [DW-1:0] pe_w [0:N-1];
`ifdef PE_LIN_FEEDER_PERF_EN
  logic [TB_CW-1:0] perf_beats, perf_bubbles;
`endif

  always #5 clk = ~clk;

  pe_lin_feeder #(.N(N), .DW(DW), .CW(TB_CW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_w     (s_w),
    .s_last  (s_last),
    .pe_fire (pe_fire),
    .pe_a    (pe_a),
    .pe_w    (pe_w),
    .busy    (busy),
    .done    (done)
`ifdef PE_LIN_FEEDER_PERF_EN
    ,
    .perf_beats   (perf_beats),
    .perf_bubbles (perf_bubbles)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: which edges accepted which beat, plus vector bookkeeping.
  int    e = 0;
  bit    hist_acc [MAXE];
  word_t hist_a   [MAXE];
  word_t hist_w   [MAXE][N];
  bit    in_vec   = 1'b0;
  int    last_e   = -1;
  int    m_beats  = 0;
  int    m_bubbles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][DW-1:0] rand_w();
    logic [N-1:0][DW-1:0] r;
    for (int i = 0; i < N; i++) r[i] = DW'($urandom);
    return r;
  endfunction

  task automatic step(input bit v, input word_t a, input logic [N-1:0][DW-1:0] wv, input bit last);
    bit    exp_ready, acc, exp_done, exp_busy;
    word_t exp_w;
    int    c, j;
    if (last_e >= 0 && e > last_e + N + 1) begin
      in_vec = 1'b0;
      last_e = -1;
    end
    exp_ready = !(last_e >= 0 && e >= last_e + 1 && e <= last_e + N + 1);
    s_valid = v;
    s_a     = a;
    for (int i = 0; i < N; i++) s_w[i] = wv[i];
    s_last  = last;
    chk("s_ready", s_ready, exp_ready);
    acc = v && exp_ready;
    hist_acc[e] = acc;
    hist_a[e]   = a;
    for (int i = 0; i < N; i++) hist_w[e][i] = wv[i];
    if (acc) begin
      if (!in_vec) begin
        in_vec    = 1'b1;
        m_beats   = 0;
        m_bubbles = 0;
      end
      if (m_beats < SATV) m_beats++;
      if (last) last_e = e;
    end else if (in_vec && last_e < 0 && !v) begin
      if (m_bubbles < SATV) m_bubbles++;
    end
    @(posedge clk);
    #1;
    c = e + 1;
    chk("pe_fire", pe_fire, hist_acc[e]);
    chk("pe_a", pe_a, hist_acc[e] ? hist_a[e] : '0);
    for (int i = 0; i < N; i++) begin
      j = e - i;
      exp_w = (j >= 0 && hist_acc[j]) ? hist_w[j][i] : '0;
      chk($sformatf("pe_w%0d", i), pe_w[i], exp_w);
    end
    exp_done = (last_e >= 0 && c == last_e + N + 1);
    exp_busy = in_vec && !(last_e >= 0 && c >= last_e + N + 1);
    chk("done", done, exp_done);
    chk("busy", busy, exp_busy);
`ifdef PE_LIN_FEEDER_PERF_EN
    chk("perf_beats", perf_beats, m_beats);
    chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    e++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0);
  endtask

  logic [N-1:0][DW-1:0] wv;

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_a     = '0;
    s_last  = 1'b0;
    for (int i = 0; i < N; i++) s_w[i] = '0;
    #3;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_pe_fire", pe_fire, 1'b0);
    chk("rst_pe_a", pe_a, '0);
    for (int i = 0; i < N; i++) chk($sformatf("rst_pe_w%0d", i), pe_w[i], '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    #9 rstn = 1'b1;

    // Single-beat vector.
    for (int i = 0; i < N; i++) wv[i] = DW'(i + 1);
    step(1'b1, 8'd3, wv, 1'b1);
    idle(6);

    // Back-to-back 4-beat vector, w[i] = 10*k + i.
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < N; i++) wv[i] = DW'(10 * k + i);
      step(1'b1, DW'(k), wv, k == 4);
    end
    idle(6);

    // Bubble in the middle of a vector.
    step(1'b1, DW'($urandom), rand_w(), 1'b0);
    step(1'b0, DW'($urandom), rand_w(), 1'b1);
    step(1'b1, DW'($urandom), rand_w(), 1'b0);
    step(1'b1, DW'($urandom), rand_w(), 1'b1);
    idle(6);
`ifdef PE_LIN_FEEDER_PERF_EN
    chk("bubble_vec_beats", perf_beats, 3);
    chk("bubble_vec_bubbles", perf_bubbles, 1);
`endif

    // Valid held high through DRAIN/DONE; the sixth held beat opens the next vector.
    step(1'b1, DW'($urandom), rand_w(), 1'b0);
    step(1'b1, DW'($urandom), rand_w(), 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, DW'($urandom), rand_w(), 1'b0);
    step(1'b1, DW'($urandom), rand_w(), 1'b1);
    idle(6);

    // Asynchronous reset after two beats of a stream.
    step(1'b1, DW'($urandom), rand_w(), 1'b0);
    step(1'b1, DW'($urandom), rand_w(), 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_pe_fire", pe_fire, 1'b0);
    chk("mid_rst_pe_a", pe_a, '0);
    for (int i = 0; i < N; i++) chk($sformatf("mid_rst_pe_w%0d", i), pe_w[i], '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    for (int k = 0; k < MAXE; k++) hist_acc[k] = 1'b0;
    in_vec    = 1'b0;
    last_e    = -1;
    m_beats   = 0;
    m_bubbles = 0;
    #3 rstn = 1'b1;
    idle(3);
    for (int i = 0; i < N; i++) wv[i] = DW'(i + 1);
    step(1'b1, 8'd3, wv, 1'b1);
    idle(6);

    // Random vector with gaps; s_last on idle cycles must be ignored.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 7) step(1'b1, DW'($urandom), rand_w(), 1'b0);
      else                          step(1'b0, DW'($urandom), rand_w(), 1'($urandom));
    end
    step(1'b1, DW'($urandom), rand_w(), 1'b1);
    idle(6);

    // Long vector exercising perf saturation.
    for (int k = 0; k < 20; k++) step(1'b1, DW'($urandom), rand_w(), k == 19);
    idle(6);
`ifdef PE_LIN_FEEDER_PERF_EN
    chk("sat_beats", perf_beats, 15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
